// File: rtl/mem_stage_lanes.sv
// Memory/writeback stage for the lane-packed data memory.
// Does lane and full-word loads/stores against an internal registered-read RAM.
// Registers the M->W bundle with stall and flush.
// Lane alignment and sign extension of loads happen on the W side, from
// controls registered together with the RAM read.
// Lane 0 is the most significant lane of a word.
module mem_stage_lanes #(
  parameter int LANES    = 3,
  parameter int LANE_W   = 8,
  parameter int DATA_W   = 18,
  parameter int ADDR_W   = 10,
  // Named RD_IDX_W because RD_W is already taken by an output port.
  parameter int RD_IDX_W = 5,
  parameter int PC_W     = 9,
  localparam int SEL_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RegWriteM,
  input  logic                MemWriteM,
  input  logic                ResultSrcM,
  input  logic [RD_IDX_W-1:0] RD_M,
  input  logic [PC_W-1:0]     PCPlus4M,
  input  logic [DATA_W-1:0]   ALU_ResultM,
  input  logic [DATA_W-1:0]   WriteDataM,
  input  logic [SEL_W-1:0]    LaneSelM,
  input  logic                WordM,
  input  logic                SextM,
  input  logic                StallM,
  input  logic                FlushW,
  output logic                RegWriteW,
  output logic                ResultSrcW,
  output logic [RD_IDX_W-1:0] RD_W,
  output logic [PC_W-1:0]     PCPlus4W,
  output logic [DATA_W-1:0]   ALU_ResultW,
  output logic [DATA_W-1:0]   ReadDataW,
  output logic                LaneErr
);

  localparam int WORD_W = LANES * LANE_W;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam logic [31:0] LANES_U = 32'(LANES);

  logic [WORD_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic              illegal;
  logic              we;
  logic              capture;
  logic [LANES-1:0]  lane_en;
  logic [WORD_W-1:0] wdata;

  logic [WORD_W-1:0] rd_q;
  logic [SEL_W-1:0]  lane_q;
  logic              word_q;
  logic              sext_q;
  logic              err_q;

  logic [LANE_W-1:0] lane_val;
  logic [DATA_W-1:0] rdata;

  // Upper address bits are dropped, so addresses alias modulo DEPTH.
  assign addr    = ALU_ResultM[ADDR_W-1:0];
  assign illegal = !WordM && (32'(LaneSelM) >= LANES_U) && (MemWriteM || ResultSrcM);
  // A stall (alone or under a flush) and reset both block the store.
  assign we      = MemWriteM && !illegal && !StallM && !rst;
  // Flush takes priority over stall, so a flushed cycle still advances W.
  assign capture = FlushW || !StallM;
  // Lane stores replicate the low lane of the store data; lane_en picks the target.
  assign wdata   = WordM ? WORD_W'(WriteDataM) : {LANES{WriteDataM[LANE_W-1:0]}};

  // Lane byte-enables for the store.
  always_comb begin
    lane_en = '0;
    if (WordM) begin
      lane_en = '1;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (LaneSelM == SEL_W'(i)) lane_en[i] = 1'b1;
      end
    end
  end

  // RAM write port with per-lane enables. RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_en[i]) begin
          mem[addr][WORD_W-1-i*LANE_W -: LANE_W] <= wdata[WORD_W-1-i*LANE_W -: LANE_W];
        end
      end
    end
  end

  // M->W pipeline register and registered RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      rd_q        <= '0;
      lane_q      <= '0;
      word_q      <= 1'b0;
      sext_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (capture) begin
      RegWriteW   <= FlushW ? 1'b0 : RegWriteM;
      ResultSrcW  <= FlushW ? 1'b0 : ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      rd_q        <= mem[addr];
      lane_q      <= LaneSelM;
      word_q      <= WordM;
      sext_q      <= SextM;
      err_q       <= illegal;
    end
  end

  // Sticky illegal-lane flag; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      LaneErr <= 1'b0;
    end else if (illegal) begin
      LaneErr <= 1'b1;
    end
  end

  // W-side lane alignment and zero/sign extension of the load result.
  always_comb begin
    lane_val = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == SEL_W'(i)) lane_val = rd_q[WORD_W-1-i*LANE_W -: LANE_W];
    end
    if (err_q) begin
      rdata = '0;
    end else if (word_q) begin
      rdata = DATA_W'(rd_q);
    end else if (sext_q) begin
      rdata = DATA_W'($signed(lane_val));
    end else begin
      rdata = DATA_W'(lane_val);
    end
  end

  assign ReadDataW = rdata;

endmodule

// File: tb/tb_mem_stage_lanes.sv
// Directed bench for mem_stage_lanes with hand-computed expected values.
module tb_mem_stage_lanes;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_m, mem_write_m, result_src_m;
  logic [4:0]  rd_m;
  logic [8:0]  pc_plus4_m;
  logic [17:0] alu_result_m, write_data_m;
  logic [1:0]  lane_sel_m;
  logic        word_m, sext_m, stall_m, flush_w;
  logic        reg_write_w, result_src_w;
  logic [4:0]  rd_w;
  logic [8:0]  pc_plus4_w;
  logic [17:0] alu_result_w, read_data_w;
  logic        lane_err;

  int n_vec = 0;
  int n_err = 0;

  mem_stage_lanes dut (
    .clk(clk), .rst(rst),
    .RegWriteM(reg_write_m), .MemWriteM(mem_write_m), .ResultSrcM(result_src_m),
    .RD_M(rd_m), .PCPlus4M(pc_plus4_m), .ALU_ResultM(alu_result_m),
    .WriteDataM(write_data_m), .LaneSelM(lane_sel_m), .WordM(word_m), .SextM(sext_m),
    .StallM(stall_m), .FlushW(flush_w),
    .RegWriteW(reg_write_w), .ResultSrcW(result_src_w), .RD_W(rd_w),
    .PCPlus4W(pc_plus4_w), .ALU_ResultW(alu_result_w), .ReadDataW(read_data_w),
    .LaneErr(lane_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write_m = 0; mem_write_m = 0; result_src_m = 0;
    rd_m = '0; pc_plus4_m = '0; alu_result_m = '0; write_data_m = '0;
    lane_sel_m = '0; word_m = 0; sext_m = 0; stall_m = 0; flush_w = 0;
  endtask

  task automatic store(input logic [17:0] a, input logic [1:0] lane, input logic word,
                       input logic [17:0] d);
    idle();
    mem_write_m = 1; alu_result_m = a; lane_sel_m = lane; word_m = word; write_data_m = d;
    tick();
  endtask

  task automatic load(input logic [17:0] a, input logic [1:0] lane, input logic word,
                      input logic sext);
    idle();
    result_src_m = 1; reg_write_m = 1; alu_result_m = a;
    lane_sel_m = lane; word_m = word; sext_m = sext;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_regwrite"}, 32'(reg_write_w), 0);
    check({tag, "_resultsrc"}, 32'(result_src_w), 0);
    check({tag, "_rd"}, 32'(rd_w), 0);
    check({tag, "_pc"}, 32'(pc_plus4_w), 0);
    check({tag, "_alu"}, 32'(alu_result_w), 0);
    check({tag, "_rdata"}, 32'(read_data_w), 0);
    check({tag, "_laneerr"}, 32'(lane_err), 0);
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    check_all_zero("reset");

    // Latency: values appear one edge later, zero before it.
    reg_write_m = 1; rd_m = 5'h1F; pc_plus4_m = 9'h104; alu_result_m = 18'h3ABCD;
    #2;
    check("lat_before_regwrite", 32'(reg_write_w), 0);
    check("lat_before_rd", 32'(rd_w), 0);
    tick();
    check("lat_regwrite", 32'(reg_write_w), 1);
    check("lat_rd", 32'(rd_w), 32'h1F);
    check("lat_pc", 32'(pc_plus4_w), 32'h104);
    check("lat_alu", 32'(alu_result_w), 32'h3ABCD);

    // Lane stores then word and lane loads.
    store(18'd5, 2'd0, 0, 18'h000AA);
    store(18'd5, 2'd1, 0, 18'h3FFBB);
    store(18'd5, 2'd2, 0, 18'h000CC);
    load(18'd5, 2'd0, 1, 0);
    check("word_load_5", 32'(read_data_w), 32'h2BBCC);
    check("word_load_resultsrc", 32'(result_src_w), 1);
    load(18'd5, 2'd0, 0, 1);
    check("lane0_sext", 32'(read_data_w), 32'h3FFAA);
    load(18'd5, 2'd2, 0, 0);
    check("lane2_zext", 32'(read_data_w), 32'h000CC);

    // Sign extension.
    store(18'd7, 2'd1, 0, 18'h00080);
    load(18'd7, 2'd1, 0, 0);
    check("sext0", 32'(read_data_w), 32'h00080);
    load(18'd7, 2'd1, 0, 1);
    check("sext1", 32'(read_data_w), 32'h3FF80);

    // Stall holds W and blocks the store.
    store(18'd2, 2'd0, 1, 18'h00111);
    load(18'd2, 2'd0, 1, 0);
    rd_m = 5'd3;
    idle();
    result_src_m = 1; reg_write_m = 1; alu_result_m = 18'd2; word_m = 1; rd_m = 5'd3;
    tick();
    check("pre_stall_rdata", 32'(read_data_w), 32'h00111);
    idle();
    stall_m = 1; mem_write_m = 1; word_m = 1; alu_result_m = 18'd2;
    write_data_m = 18'h3FFFF; rd_m = 5'd9; pc_plus4_m = 9'h1AA;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_rd", 32'(rd_w), 32'd3);
      check("stall_regwrite", 32'(reg_write_w), 1);
      check("stall_rdata", 32'(read_data_w), 32'h00111);
    end
    load(18'd2, 2'd0, 1, 0);
    check("stall_no_store", 32'(read_data_w), 32'h00111);

    // Flush, and flush together with stall.
    idle();
    flush_w = 1; reg_write_m = 1; result_src_m = 1; alu_result_m = 18'd2; word_m = 1;
    tick();
    check("flush_regwrite", 32'(reg_write_w), 0);
    check("flush_resultsrc", 32'(result_src_w), 0);
    idle();
    flush_w = 1; stall_m = 1; reg_write_m = 1; mem_write_m = 1; word_m = 1;
    alu_result_m = 18'd2; write_data_m = 18'h2AAAA;
    tick();
    check("flush_stall_regwrite", 32'(reg_write_w), 0);
    load(18'd2, 2'd0, 1, 0);
    check("flush_stall_no_store", 32'(read_data_w), 32'h00111);

    // Illegal lane select.
    store(18'd9, 2'd0, 1, 18'h0ABCD);
    check("laneerr_clear", 32'(lane_err), 0);
    store(18'd9, 2'd3, 0, 18'h000FF);
    check("laneerr_set", 32'(lane_err), 1);
    idle();
    for (int i = 0; i < 10; i++) tick();
    check("laneerr_sticky", 32'(lane_err), 1);
    load(18'd9, 2'd0, 1, 0);
    check("illegal_no_store", 32'(read_data_w), 32'h0ABCD);
    load(18'd9, 2'd3, 0, 0);
    check("illegal_load_zero", 32'(read_data_w), 0);

    // Address wrap.
    store(18'h400, 2'd0, 1, 18'h12345);
    load(18'h000, 2'd0, 1, 0);
    check("wrap_load", 32'(read_data_w), 32'h12345);

    // Reset during a store: outputs clear, store suppressed.
    idle();
    rst = 1; mem_write_m = 1; word_m = 1; alu_result_m = 18'd0;
    write_data_m = 18'h3FFFF; reg_write_m = 1;
    tick();
    rst = 0;
    idle();
    check_all_zero("rst_mid");
    load(18'd0, 2'd0, 1, 0);
    check("rst_no_store", 32'(read_data_w), 32'h12345);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
